pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program counter, instruction register and 8-level hardware return stack for the PIC16-compatible core. Sits directly upstream of `instruction_decoder`:
- drives `pmem_addr` to program memory;
- latches the returned word into `instr_current`;
- updates the PC in response to the decoder's fetch and branch strobes `instr_rd_en`, `instr_flush`, `pc_incr_en` and `pc_j_en`, plus call, return and PCL-write strobes.

## Interface
Parameters:
- `PC_W`, 13: program counter width (8K words).
- `STACK_DEPTH`, 8: return stack entries; must be a power of two.
- `NOP_WORD`, 14'h0000: encoding loaded on flush or reset.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  core clock
  - `rst`  in  1  synchronous, active-high reset
- Program memory:
  - `pmem_addr`  out  PC_W  equals `pc`; combinational from the PC register
  - `pmem_data`  in  14  word at `pmem_addr`, valid in the same cycle (async ROM)
- Instruction register:
  - `instr_current`  out  14  instruction register, to the decoder
- Decoder strobes:
  - `instr_rd_en`  in  1  load `pmem_data` into `instr_current`
  - `instr_flush`  in  1  load `NOP_WORD` into `instr_current`
  - `pc_incr_en`  in  1  pc <= pc+1
  - `pc_j_en`  in  1  goto: pc <= {pclath[4:3], instr_current[10:0]}
  - `pc_call_en`  in  1  call: push pc, then jump as `pc_j_en`
  - `pc_ret_en`  in  1  return/retlw/retfie: pc <= popped entry
  - `pcl_wr_en`  in  1  PCL written: pc <= {pclath[4:0], pcl_data}
  - `pcl_data`  in  8  new PCL value
- PCLATH:
  - `pclath`  in  5  PCLATH register contents
- PC and stack status:
  - `pc`  out  PC_W  current program counter
  - `stk_ovf`  out  1  sticky: push with 8 entries live
  - `stk_unf`  out  1  sticky: pop with 0 entries live

## Operation
- `pc` always points at the next word to fetch; `instr_current` holds the word executing.
- Instruction register:
  - `instr_flush` has priority over `instr_rd_en`.
  - Neither asserted: hold.
- PC update priority, highest first:
  - `rst`
  - `pc_call_en`
  - `pc_j_en`
  - `pc_ret_en`
  - `pcl_wr_en`
  - `pc_incr_en`
  - hold
- Only the winning source updates the PC. Push and pop occur only when call or ret respectively wins.
- Increment wraps: 13'h1FFF + 1 = 13'h0000.
- Call pushes the pre-update `pc`, which is the return address because `pc` already points past the call.
- Stack is circular, matching PIC16:
  - 3-bit pointer; push writes `[ptr]` then ptr+1; pop reads `[ptr-1]` then ptr-1.
  - A push at full overwrites the oldest entry and sets `stk_ovf`.
  - A pop at empty returns the wrapped entry and sets `stk_unf`.
  - Separate depth counter, 0..8, saturates at both ends.
- Flags clear only on `rst`.
- Reset values:
  - `pc` = 0, `instr_current` = `NOP_WORD`, pointer 0, depth 0
  - `stk_ovf` = `stk_unf` = 0
  - stack contents undefined

## Timing
- All registers update on the rising `clk` edge.
- `pmem_addr` is combinational from `pc`.
- Fetch-and-advance: the decoder asserts `instr_rd_en` and `pc_incr_en` together in q3. At that edge, `instr_current` takes the word at the old `pc`, and `pc` becomes old+1.
- Skip: `instr_flush` + `pc_incr_en` discards the word at `pc` (NOP executes next) and advances.
- Goto/call: `instr_flush` + `pc_j_en`/`pc_call_en`; the target is formed from `instr_current` before the flush takes effect. The NOP runs one 4-cycle slot, then the target is fetched. Branch total is 8 cycles.
- PC-modifying strobes take effect in one cycle; no internal wait states.
- `rst` mid-instruction: all state returns to reset values at that edge; strobes in the same cycle are ignored.

## Structure
- Shared header `core_params.vh`: `PC_W`, `STACK_DEPTH`, `NOP_WORD`. `isa_nop` in `isa.vh` must equal `NOP_WORD`.
- Sub-module `hw_stack`: circular register-file LIFO.
  - Ports: `clk`, `rst`, `push`, `pop`, `din`, `dout`, `ovf`, `unf`.
  - `pop` data is combinational from `[ptr-1]`.
- `pc_fetch_unit` holds the PC register, the instruction register, the priority mux and the sticky flags.

## Test plan
- Reset, then hold `instr_rd_en` + `pc_incr_en` pulses every 4th cycle with ROM[a] = a+0x100 → `instr_current` = 0x100, 0x101, 0x102 on successive q3s; `pc` = 1, 2, 3.
- `instr_current` = goto 0x123, `pclath` = 5'b11000, `pc_j_en` + `instr_flush` → `pc` = 0x1923, `instr_current` = 0x0000 next cycle.
- Skip: `instr_flush` + `pc_incr_en` at pc = 0x010 → `instr_current` = NOP, `pc` = 0x011, ROM[0x010] never loaded.
- Nine nested calls from pc = 0x020+k, then nine returns:
  - `stk_ovf` = 1 after the ninth call;
  - returns yield 0x028 … 0x021 and then 0x028 again;
  - `stk_unf` = 1 after the ninth return.
- Simultaneous `pc_call_en` + `pcl_wr_en` + `pc_incr_en` → call wins, one push, and the PCL write is ignored. Also, `pc` = 0x1FFF + incr → `pc` = 0x0000.
- `rst` asserted mid-call with the stack at depth 3 → `pc` = 0, depth 0, flags 0, `instr_current` = 0x0000. A following pop sets `stk_unf`.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PIC16-compatible fetch unit.
//   - default widths and reset encodings
//   - PC source selector used by the next-PC priority mux
//   - target-address helpers for goto/call and PCL writes
package pc_fetch_unit_pkg;

    localparam int INSTR_W         = 14;
    localparam int PC_W_DEF        = 13;
    localparam int STACK_DEPTH_DEF = 8;
    localparam logic [INSTR_W-1:0] NOP_WORD_DEF = 14'h0000;

    // Winning source for the next program counter value
    typedef enum logic [2:0] {
        SRC_HOLD = 3'd0,
        SRC_CALL = 3'd1,
        SRC_JUMP = 3'd2,
        SRC_RET  = 3'd3,
        SRC_PCL  = 3'd4,
        SRC_INCR = 3'd5
    } pc_src_e;

    // goto/call target: PCLATH<4:3> selects the 2K page, opcode supplies the low 11 bits
    function automatic logic [12:0] goto_target(input logic [1:0]  page,
                                                input logic [10:0] offset);
        return {page, offset};
    endfunction

    // Computed jump through PCL: all of PCLATH forms the upper bits
    function automatic logic [12:0] pcl_target(input logic [4:0] pclath,
                                               input logic [7:0] pcl);
        return {pclath, pcl};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_hw_stack.sv
// hw_stack: circular register-file return stack.
//   clk, rst : clock and synchronous active-high reset (pointer and depth only)
//   push     : write din at [ptr], then ptr+1
//   pop      : ptr-1; dout is combinational from [ptr-1]
//   din/dout : return address in / out
//   ovf/unf  : single-cycle event, push at full / pop at empty
// The pointer simply wraps, so a push at full overwrites the oldest entry and
// a pop at empty returns whatever the wrapped slot holds, as on PIC16 parts.
module hw_stack #(
    parameter int DATA_W = 13,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              ovf,
    output logic              unf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1'b1);
    localparam logic [PTR_W:0]   DEPTH_ONE  = (PTR_W+1)'(1'b1);
    localparam logic [PTR_W:0]   DEPTH_ZERO = (PTR_W+1)'(1'b0);
    localparam logic [PTR_W:0]   DEPTH_FULL = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  ptr_r;
    logic [PTR_W:0]    depth_r;
    logic              full_s;
    logic              empty_s;

    assign full_s  = (depth_r == DEPTH_FULL);
    assign empty_s = (depth_r == DEPTH_ZERO);
    assign dout    = mem_r[ptr_r - PTR_ONE];
    assign ovf     = push & full_s;
    assign unf     = pop & empty_s;

    // Entry storage; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[ptr_r] <= din;
        end
    end

    // Wrapping pointer and saturating live-entry count
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r   <= {PTR_W{1'b0}};
            depth_r <= DEPTH_ZERO;
        end else if (push) begin
            ptr_r <= ptr_r + PTR_ONE;
            if (!full_s) begin
                depth_r <= depth_r + DEPTH_ONE;
            end
        end else if (pop) begin
            ptr_r <= ptr_r - PTR_ONE;
            if (!empty_s) begin
                depth_r <= depth_r - DEPTH_ONE;
            end
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, instruction register and return stack.
//   clk, rst        : core clock, synchronous active-high reset
//   pmem_addr       : program memory address (= pc)
//   pmem_data       : async ROM word at pmem_addr
//   instr_current   : instruction register, to the decoder
//   instr_rd_en     : load pmem_data into instr_current
//   instr_flush     : load NOP_WORD into instr_current (wins over rd)
//   pc_incr_en      : pc <= pc + 1 (wraps)
//   pc_j_en         : goto, pc <= {pclath[4:3], instr_current[10:0]}
//   pc_call_en      : push pc, then jump as goto
//   pc_ret_en       : pc <= popped return address
//   pcl_wr_en       : pc <= {pclath, pcl_data}
//   pcl_data        : new PCL value
//   pclath          : PCLATH register contents
//   pc              : current program counter
//   stk_ovf/stk_unf : sticky stack overflow / underflow flags
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int                 PC_W        = PC_W_DEF,
    parameter int                 STACK_DEPTH = STACK_DEPTH_DEF,
    parameter logic [INSTR_W-1:0] NOP_WORD    = NOP_WORD_DEF
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    pmem_addr,
    input  logic [INSTR_W-1:0] pmem_data,
    output logic [INSTR_W-1:0] instr_current,
    input  logic               instr_rd_en,
    input  logic               instr_flush,
    input  logic               pc_incr_en,
    input  logic               pc_j_en,
    input  logic               pc_call_en,
    input  logic               pc_ret_en,
    input  logic               pcl_wr_en,
    input  logic [7:0]         pcl_data,
    input  logic [4:0]         pclath,
    output logic [PC_W-1:0]    pc,
    output logic               stk_ovf,
    output logic               stk_unf
);

    logic [PC_W-1:0]    pc_r;
    logic [INSTR_W-1:0] ir_r;
    logic               stk_ovf_r;
    logic               stk_unf_r;

    pc_src_e            pc_src_s;
    logic [PC_W-1:0]    pc_next_s;
    logic [PC_W-1:0]    goto_pc_s;
    logic [PC_W-1:0]    pcl_pc_s;
    logic [PC_W-1:0]    ret_pc_s;
    logic               push_s;
    logic               pop_s;
    logic               ovf_evt_s;
    logic               unf_evt_s;

    // Target is taken from the instruction register before any flush lands
    assign goto_pc_s = PC_W'(goto_target(pclath[4:3], ir_r[10:0]));
    assign pcl_pc_s  = PC_W'(pcl_target(pclath, pcl_data));

    // Only the winning source may touch the stack
    assign push_s = (pc_src_s == SRC_CALL);
    assign pop_s  = (pc_src_s == SRC_RET);

    hw_stack #(
        .DATA_W (PC_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk  (clk),
        .rst  (rst),
        .push (push_s),
        .pop  (pop_s),
        .din  (pc_r),
        .dout (ret_pc_s),
        .ovf  (ovf_evt_s),
        .unf  (unf_evt_s)
    );

    // Strobe priority: call > goto > return > PCL write > increment > hold
    always_comb begin
        pc_src_s = SRC_HOLD;
        if (pc_call_en) begin
            pc_src_s = SRC_CALL;
        end else if (pc_j_en) begin
            pc_src_s = SRC_JUMP;
        end else if (pc_ret_en) begin
            pc_src_s = SRC_RET;
        end else if (pcl_wr_en) begin
            pc_src_s = SRC_PCL;
        end else if (pc_incr_en) begin
            pc_src_s = SRC_INCR;
        end else begin
            pc_src_s = SRC_HOLD;
        end
    end

    // Next-PC mux driven by the selected source
    always_comb begin
        pc_next_s = pc_r;
        case (pc_src_s)
            SRC_CALL: pc_next_s = goto_pc_s;
            SRC_JUMP: pc_next_s = goto_pc_s;
            SRC_RET:  pc_next_s = ret_pc_s;
            SRC_PCL:  pc_next_s = pcl_pc_s;
            SRC_INCR: pc_next_s = pc_r + PC_W'(1'b1);
            SRC_HOLD: pc_next_s = pc_r;
            default:  pc_next_s = pc_r;
        endcase
    end

    // PC, instruction register and sticky stack flags
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r      <= {PC_W{1'b0}};
            ir_r      <= NOP_WORD;
            stk_ovf_r <= 1'b0;
            stk_unf_r <= 1'b0;
        end else begin
            pc_r <= pc_next_s;
            if (instr_flush) begin
                ir_r <= NOP_WORD;
            end else if (instr_rd_en) begin
                ir_r <= pmem_data;
            end
            stk_ovf_r <= stk_ovf_r | ovf_evt_s;
            stk_unf_r <= stk_unf_r | unf_evt_s;
        end
    end

    assign pc            = pc_r;
    assign pmem_addr     = pc_r;
    assign instr_current = ir_r;
    assign stk_ovf       = stk_ovf_r;
    assign stk_unf       = stk_unf_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: the stimulus process drives strobes on
// the falling edge, advances a behavioural model and queues the expected
// post-edge state; a monitor pops and compares after every rising edge.
module tb_pc_fetch_unit;

    localparam logic [7:0] S_RST  = 8'h01;
    localparam logic [7:0] S_RD   = 8'h02;
    localparam logic [7:0] S_FL   = 8'h04;
    localparam logic [7:0] S_INC  = 8'h08;
    localparam logic [7:0] S_J    = 8'h10;
    localparam logic [7:0] S_CALL = 8'h20;
    localparam logic [7:0] S_RET  = 8'h40;
    localparam logic [7:0] S_PW   = 8'h80;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] pmem_addr;
    logic [13:0] pmem_data;
    logic [13:0] instr_current;
    logic        instr_rd_en = 1'b0, instr_flush = 1'b0, pc_incr_en = 1'b0;
    logic        pc_j_en = 1'b0, pc_call_en = 1'b0, pc_ret_en = 1'b0, pcl_wr_en = 1'b0;
    logic [7:0]  pcl_data = 8'h00;
    logic [4:0]  pclath = 5'h00;
    logic [12:0] pc;
    logic        stk_ovf, stk_unf;

    logic [13:0] rom [8192];
    assign pmem_data = rom[pmem_addr];

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk(clk), .rst(rst), .pmem_addr(pmem_addr), .pmem_data(pmem_data),
        .instr_current(instr_current), .instr_rd_en(instr_rd_en),
        .instr_flush(instr_flush), .pc_incr_en(pc_incr_en), .pc_j_en(pc_j_en),
        .pc_call_en(pc_call_en), .pc_ret_en(pc_ret_en), .pcl_wr_en(pcl_wr_en),
        .pcl_data(pcl_data), .pclath(pclath), .pc(pc),
        .stk_ovf(stk_ovf), .stk_unf(stk_unf)
    );

    typedef struct {
        int          pc;
        logic [13:0] ir;
        logic        ovf;
        logic        unf;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   step_no = 0;

    // Behavioural model: integer PC, 8-slot circular stack with live count
    int          m_pc;
    logic [13:0] m_ir;
    int          m_stk[8];
    int          m_ptr, m_depth;
    logic        m_ovf, m_unf;

    task automatic model_step(input logic [7:0] s, input logic [7:0] pd, input logic [4:0] lath);
        int          old_pc;
        logic [13:0] old_ir;
        old_pc = m_pc;
        old_ir = m_ir;
        if ((s & S_RST) != 8'h00) begin
            m_pc = 0; m_ir = 14'h0000; m_ptr = 0; m_depth = 0;
            m_ovf = 1'b0; m_unf = 1'b0;
            return;
        end
        if ((s & S_FL) != 8'h00)      m_ir = 14'h0000;
        else if ((s & S_RD) != 8'h00) m_ir = rom[old_pc];
        if ((s & S_CALL) != 8'h00) begin
            if (m_depth == 8) m_ovf = 1'b1; else m_depth = m_depth + 1;
            m_stk[m_ptr] = old_pc;
            m_ptr = (m_ptr + 1) % 8;
            m_pc = (int'(lath) / 8) * 2048 + (int'(old_ir) % 2048);
        end else if ((s & S_J) != 8'h00) begin
            m_pc = (int'(lath) / 8) * 2048 + (int'(old_ir) % 2048);
        end else if ((s & S_RET) != 8'h00) begin
            if (m_depth == 0) m_unf = 1'b1; else m_depth = m_depth - 1;
            m_ptr = (m_ptr + 7) % 8;
            m_pc = m_stk[m_ptr];
        end else if ((s & S_PW) != 8'h00) begin
            m_pc = int'(lath) * 256 + int'(pd);
        end else if ((s & S_INC) != 8'h00) begin
            m_pc = (old_pc + 1) % 8192;
        end
    endtask

    task automatic step(input logic [7:0] s, input logic [7:0] pd = 8'h00, input logic [4:0] lath = 5'h00);
        exp_t e;
        @(negedge clk);
        rst         = s[0];
        instr_rd_en = s[1];
        instr_flush = s[2];
        pc_incr_en  = s[3];
        pc_j_en     = s[4];
        pc_call_en  = s[5];
        pc_ret_en   = s[6];
        pcl_wr_en   = s[7];
        pcl_data    = pd;
        pclath      = lath;
        model_step(s, pd, lath);
        step_no++;
        e.pc = m_pc; e.ir = m_ir; e.ovf = m_ovf; e.unf = m_unf; e.id = step_no;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, id, act, expv);
    endtask

    // Monitor: one queued expectation per rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc",        e.id, 32'(pc),            32'(e.pc));
                check("pmem_addr", e.id, 32'(pmem_addr),     32'(e.pc));
                check("instr",     e.id, 32'(instr_current), 32'(e.ir));
                check("stk_ovf",   e.id, 32'(stk_ovf),       32'(e.ovf));
                check("stk_unf",   e.id, 32'(stk_unf),       32'(e.unf));
            end
        end
    end

    // Stimulus
    initial begin
        logic [7:0] s;
        for (int a = 0; a < 8192; a++) rom[a] = 14'(a + 256);
        m_pc = 0; m_ir = 14'h0000; m_ptr = 0; m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
        for (int i = 0; i < 8; i++) m_stk[i] = 0;

        // Reset, then fetch-and-advance every 4th cycle
        step(S_RST); step(S_RST);
        for (int k = 0; k < 3; k++) begin
            step(8'h00); step(8'h00); step(8'h00);
            step(S_RD | S_INC);
        end

        // goto 0x123 with PCLATH page 3
        rom[3] = 14'h2923;
        step(S_RD | S_INC);
        step(S_J | S_FL, 8'h00, 5'b11000);
        step(8'h00);

        // Skip at pc 0x010
        rom[16] = 14'h3FFF;
        step(S_PW, 8'h10, 5'h00);
        step(S_FL | S_INC);
        step(8'h00);

        // Nine nested calls then nine returns
        for (int k = 0; k < 9; k++) begin
            step(S_PW, 8'(32 + k), 5'h00);
            step(S_CALL | S_FL, 8'h00, 5'h00);
        end
        for (int k = 0; k < 9; k++) step(S_RET | S_FL);

        // Call beats PCL write and increment; then the 0x1FFF wrap
        step(S_PW, 8'h44, 5'h02);
        step(S_CALL | S_PW | S_INC, 8'h99, 5'h08);
        step(S_RET);
        step(S_PW, 8'hFF, 5'h1F);
        step(S_INC);

        // Reset mid-call at depth 3, then a pop at empty
        step(S_RST);
        for (int k = 0; k < 3; k++) step(S_CALL, 8'h00, 5'(k * 8));
        step(S_RST | S_CALL | S_PW | S_RD, 8'h12, 5'h1F);
        step(8'h00);
        step(S_RET);
        step(8'h00);

        // Randomized strobe mixes against fresh ROM contents
        for (int a = 0; a < 8192; a++) rom[a] = 14'($urandom);
        step(S_RST);
        for (int n = 0; n < 600; n++) begin
            s = 8'h00;
            if ($urandom_range(0, 99) < 2)  s |= S_RST;
            if ($urandom_range(0, 99) < 50) s |= S_RD;
            if ($urandom_range(0, 99) < 15) s |= S_FL;
            if ($urandom_range(0, 99) < 50) s |= S_INC;
            if ($urandom_range(0, 99) < 10) s |= S_J;
            if ($urandom_range(0, 99) < 12) s |= S_CALL;
            if ($urandom_range(0, 99) < 12) s |= S_RET;
            if ($urandom_range(0, 99) < 8)  s |= S_PW;
            step(s, 8'($urandom), 5'($urandom));
        end
        step(8'h00);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
